muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the bus datapath.
- Replaces the single-cycle MUL path in the ALU; results feed ZHI/ZLO, then HI/LO.
- Adds signed and unsigned multiply, signed and unsigned divide, a start/busy/done handshake, divide-by-zero flagging and abort.
- The control sequencer holds its T-state until done.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; captured on accepted start.
- b  in  WIDTH  multiplier / divisor; captured on accepted start.
- abort  in  1  synchronous cancel of an operation in flight.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  MUL: upper product word; DIV: remainder.
- lo  out  WIDTH  MUL: lower product word; DIV: quotient.
- div_by_zero  out  1  set with done when a DIV/DIVU had b == 0; held until next accept.

Behaviour:
- Reset (clear low, any time, including mid-operation):
  - state IDLE; busy, done, div_by_zero = 0; hi, lo = 0; counter = 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 at edge k latches op, a, b and moves to PREP; busy=1 from k+1.
  - start=0 stays in IDLE.
- PREP (1 cycle):
  - Signed ops take magnitudes of a and b and record result signs.
    - MUL: sign = a[MSB] ^ b[MSB].
    - DIV: quotient sign = a^b; remainder sign = a.
  - Unsigned ops pass operands through.
  - DIV/DIVU with b == 0 skips ITER and goes to FIX.
  - Otherwise counter = WIDTH and next state is ITER.
- ITER (exactly WIDTH cycles, counter decrements to 0):
  - MUL: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
  - DIV: restoring division; one quotient bit per cycle, remainder in a WIDTH+1-bit register.
- FIX (1 cycle):
  - Apply two's-complement negation per recorded signs.
  - Divide-by-zero result: lo = all ones, hi = a (original dividend), div_by_zero = 1.
  - Signed MIN / -1 result: lo = MIN, hi = 0 (wraps, no flag).
  - Register hi/lo.
- DONE (1 cycle): done=1, busy=0; then IDLE.
- Latency:
  - Normal operation: done asserted in cycle k+WIDTH+3 (PREP + WIDTH ITER + FIX + DONE).
  - Divide by zero: done asserted in cycle k+3.
  - A start in the DONE cycle is ignored; earliest re-accept is the cycle after done.
- hi/lo hold their last value until the next FIX. They do not change during busy.
- start while busy: ignored, no queueing, no error.
- abort while busy:
  - Return to IDLE next edge; no done; hi/lo and div_by_zero unchanged.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- op/a/b changes after accept have no effect.
- Arithmetic:
  - MUL/MULU produce the full 2*WIDTH product.
  - DIV truncates toward zero; remainder sign follows dividend.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU);
  - state enum muldiv_state_t (IDLE, PREP, ITER, FIX, DONE);
  - helper function for two's-complement negate.
- Single module; no sub-module.
- The ITER datapath is a shared shift register, with mode select between add and subtract-restore.

Test Plan (WIDTH=32):
- MUL a=0x00000012, b=0x00000014 -> done at accept+35 cycles, hi=0x00000000, lo=0x00000168, busy high for 34 cycles.
- MUL a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done at accept+3, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00001234; next accepted MUL clears the flag.
- MUL 6*7 accepted; second start at +5 with other operands -> ignored; result lo=42. Then start, abort at +10 -> no done, hi/lo still 42/0, IDLE next cycle.
- Start MUL, drive clear low asynchronously at +12 between edges -> busy, done, hi, lo all 0 immediately. After release, a fresh MUL 3*4 gives lo=12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   - op encodings driven on the op port
//   - FSM state type and state constants
//   - two's-complement negate helper used for magnitude and sign fix-up
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;  // signed multiply
    localparam logic [1:0] OP_MULU = 2'b01;  // unsigned multiply
    localparam logic [1:0] OP_DIV  = 2'b10;  // signed divide
    localparam logic [1:0] OP_DIVU = 2'b11;  // unsigned divide

    typedef logic [2:0] muldiv_state_t;

    localparam muldiv_state_t IDLE = 3'd0;
    localparam muldiv_state_t PREP = 3'd1;
    localparam muldiv_state_t ITER = 3'd2;
    localparam muldiv_state_t FIX  = 3'd3;
    localparam muldiv_state_t DONE = 3'd4;

    // Helper width; callers zero-extend into it and truncate back, so it covers
    // full products for operand widths up to 64 bits.
    localparam int unsigned NEG_W = 128;

    // Conditional two's-complement negate; low bits are exact after truncation.
    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] x,
                                                  input logic             en);
        return en ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle of the multiply/divide unit.
//   master: start, op, a, b, abort           -> unit
//   slave : busy, done, hi, lo, div_by_zero  -> requester
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide unit.
// Ports:
//   clock - rising-edge system clock
//   clear - asynchronous active-low reset
//   bus   - muldiv_if slave: start/op/a/b/abort in; busy/done/hi/lo/div_by_zero out
// Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
// Divide by zero skips ITER. abort in PREP/ITER/FIX returns to IDLE silently.
// MUL: hi:lo = full product. DIV: lo = quotient, hi = remainder.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clock,
    input  logic     clear,
    muldiv_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned ACC_W = 2 * WIDTH + 1;

    muldiv_state_t    state, state_nxt;
    logic [1:0]       op_r, op_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;       // original a, kept for divide-by-zero result
    logic [WIDTH-1:0] opb, opb_nxt;     // raw b until PREP, then its magnitude
    logic [ACC_W-1:0] acc, acc_nxt;     // shared shift register {upper W+1, lower W}
    logic             neg_q, neg_q_nxt; // negate product / quotient
    logic             neg_r, neg_r_nxt; // negate remainder
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hi_r, hi_nxt;
    logic [WIDTH-1:0] lo_r, lo_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             dbz_r, dbz_nxt;

    logic             is_div;
    logic             is_signed;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   alu_x;
    logic [WIDTH:0]   alu_y;
    logic [WIDTH:0]   alu_r;
    logic [WIDTH:0]   mul_sel;
    logic             div_fits;
    logic [WIDTH:0]   div_rem;
    logic [ACC_W-1:0] iter_step;
    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign is_div    = op_r[1];
    assign is_signed = ~op_r[0];
    assign acc_hi    = acc[ACC_W-1:WIDTH];
    assign acc_lo    = acc[WIDTH-1:0];

    // One adder serves both modes: add multiplicand, or trial-subtract divisor.
    assign shifted  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    assign alu_x    = is_div ? shifted : acc_hi;
    assign alu_y    = {1'b0, opb};
    assign alu_r    = is_div ? (alu_x - alu_y) : (alu_x + alu_y);

    // MUL: add when multiplier LSB set, then shift right. DIV: restore on borrow.
    assign mul_sel   = acc_lo[0] ? alu_r : acc_hi;
    assign div_fits  = ~alu_r[WIDTH];
    assign div_rem   = div_fits ? alu_r : shifted;
    assign iter_step = is_div ? {div_rem, acc_lo[WIDTH-2:0], div_fits}
                              : {1'b0, mul_sel, acc_lo[WIDTH-1:1]};

    // Operand magnitudes; |MIN| still fits as an unsigned WIDTH-bit value.
    assign sgn_a = is_signed & a_r[WIDTH-1];
    assign sgn_b = is_signed & opb[WIDTH-1];
    assign mag_a = WIDTH'(twos_neg(NEG_W'(a_r), sgn_a));
    assign mag_b = WIDTH'(twos_neg(NEG_W'(opb), sgn_b));

    // Sign fix-up; MIN / -1 falls out naturally as quotient MIN, remainder 0.
    assign prod_fix = DW'(twos_neg(NEG_W'(acc[DW-1:0]), neg_q));
    assign quot_fix = WIDTH'(twos_neg(NEG_W'(acc_lo), neg_q));
    assign rem_fix  = WIDTH'(twos_neg(NEG_W'(acc[DW-1:WIDTH]), neg_r));

    // State register and datapath registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            opb    <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_r   <= op_nxt;
            a_r    <= a_nxt;
            opb    <= opb_nxt;
            acc    <= acc_nxt;
            neg_q  <= neg_q_nxt;
            neg_r  <= neg_r_nxt;
            cnt    <= cnt_nxt;
            hi_r   <= hi_nxt;
            lo_r   <= lo_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            dbz_r  <= dbz_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        a_nxt     = a_r;
        opb_nxt   = opb;
        acc_nxt   = acc;
        neg_q_nxt = neg_q;
        neg_r_nxt = neg_r;
        cnt_nxt   = cnt;
        hi_nxt    = hi_r;
        lo_nxt    = lo_r;
        dbz_nxt   = dbz_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = PREP;
                    op_nxt    = bus.op;
                    a_nxt     = bus.a;
                    opb_nxt   = bus.b;
                    dbz_nxt   = 1'b0;
                end
            end
            PREP: begin
                acc_nxt   = {{(WIDTH + 1){1'b0}}, mag_a};
                opb_nxt   = mag_b;
                neg_q_nxt = sgn_a ^ sgn_b;
                neg_r_nxt = sgn_a;
                if (is_div && (opb == '0)) begin
                    state_nxt = FIX;
                end else begin
                    cnt_nxt   = CNT_W'(WIDTH);
                    state_nxt = ITER;
                end
            end
            ITER: begin
                acc_nxt = iter_step;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
                if (is_div && (opb == '0)) begin
                    hi_nxt  = a_r;
                    lo_nxt  = '1;
                    dbz_nxt = 1'b1;
                end else if (is_div) begin
                    hi_nxt = rem_fix;
                    lo_nxt = quot_fix;
                end else begin
                    hi_nxt = prod_fix[DW-1:WIDTH];
                    lo_nxt = prod_fix[WIDTH-1:0];
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort cancels in-flight work without touching visible results.
        if (bus.abort && ((state == PREP) || (state == ITER) || (state == FIX))) begin
            state_nxt = IDLE;
            hi_nxt    = hi_r;
            lo_nxt    = lo_r;
            dbz_nxt   = dbz_r;
        end
    end

    assign busy_nxt = (state_nxt == PREP) || (state_nxt == ITER) || (state_nxt == FIX);
    assign done_nxt = (state_nxt == DONE);

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32) with hand-computed results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clock;
    logic clear;
    int   n_vec;
    int   n_err;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, optionally poking a second start or an abort at a
    // given cycle after accept (cycle 1 = first cycle after the accepting edge).
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int poke_at, input int abort_at,
                         output int lat, output int busy_n, output logic seen,
                         output logic stable, output logic bpost);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clock);
        hi0       = bus.hi;
        lo0       = bus.lo;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.a     = ~x;
        bus.b     = ~y;
        lat    = 1;
        busy_n = 0;
        seen   = 1'b0;
        stable = 1'b1;
        bpost  = 1'b1;
        while (!seen && lat < 60) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) begin
                    busy_n++;
                    if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
                end
                if (abort_at > 0 && lat == abort_at + 1) bpost = bus.busy;
                bus.start = (lat == poke_at);
                bus.abort = (lat == abort_at);
                if (lat == poke_at) begin
                    bus.op = OP_MULU;
                    bus.a  = 32'd100;
                    bus.b  = 32'd100;
                end
                @(negedge clock);
                lat++;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    vec_t vt [10];
    int   lat;
    int   busy_n;
    logic seen;
    logic stable;
    logic bpost;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        clear     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;

        vt[0] = '{OP_MUL,  32'h00000012, 32'h00000014, 32'h00000000, 32'h00000168, 1'b0, 35};
        vt[1] = '{OP_MUL,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 35};
        vt[2] = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
        vt[3] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
        vt[4] = '{OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
        vt[5] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
        vt[6] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
        vt[7] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35};
        vt[8] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 3};
        vt[9] = '{OP_DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 3};

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_hi",   64'(bus.hi),   64'(0));
        check("rst_lo",   64'(bus.lo),   64'(0));
        check("rst_dbz",  64'(bus.div_by_zero), 64'(0));
        clear = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, 0, 0, lat, busy_n, seen, stable, bpost);
            check($sformatf("v%0d_done", i),   64'(seen),   64'(1));
            check($sformatf("v%0d_lat", i),    64'(lat),    64'(vt[i].lat));
            check($sformatf("v%0d_busy_n", i), 64'(busy_n), 64'(vt[i].lat - 1));
            check($sformatf("v%0d_hi", i),     64'(bus.hi), 64'(vt[i].hi));
            check($sformatf("v%0d_lo", i),     64'(bus.lo), 64'(vt[i].lo));
            check($sformatf("v%0d_dbz", i),    64'(bus.div_by_zero), 64'(vt[i].dbz));
            check($sformatf("v%0d_stable", i), 64'(stable), 64'(1));
        end

        // Start during the DONE cycle is ignored; flag stays set.
        bus.op    = OP_MUL;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("done_start_busy", 64'(bus.busy), 64'(0));
        check("done_start_dbz",  64'(bus.div_by_zero), 64'(1));

        // Second start while busy is ignored; accept clears the flag.
        do_op(OP_MUL, 32'd6, 32'd7, 5, 0, lat, busy_n, seen, stable, bpost);
        check("poke_done", 64'(seen),   64'(1));
        check("poke_lat",  64'(lat),    64'(35));
        check("poke_lo",   64'(bus.lo), 64'(42));
        check("poke_hi",   64'(bus.hi), 64'(0));
        check("poke_dbz",  64'(bus.div_by_zero), 64'(0));

        // Abort mid-iteration: no done, results untouched, idle next cycle.
        do_op(OP_MUL, 32'd9, 32'd9, 0, 10, lat, busy_n, seen, stable, bpost);
        check("abort_no_done", 64'(seen),     64'(0));
        check("abort_idle",    64'(bpost),    64'(0));
        check("abort_lo",      64'(bus.lo),   64'(42));
        check("abort_hi",      64'(bus.hi),   64'(0));
        check("abort_busy",    64'(bus.busy), 64'(0));

        // Asynchronous reset in the middle of an operation.
        @(negedge clock);
        bus.op    = OP_MULU;
        bus.a     = 32'h0000FFFF;
        bus.b     = 32'h0000FFFF;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (11) @(negedge clock);
        #2 clear = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_done", 64'(bus.done), 64'(0));
        check("arst_hi",   64'(bus.hi),   64'(0));
        check("arst_lo",   64'(bus.lo),   64'(0));
        check("arst_dbz",  64'(bus.div_by_zero), 64'(0));
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("arst_idle", 64'(bus.busy), 64'(0));

        do_op(OP_MUL, 32'd3, 32'd4, 0, 0, lat, busy_n, seen, stable, bpost);
        check("post_rst_done", 64'(seen),   64'(1));
        check("post_rst_lat",  64'(lat),    64'(35));
        check("post_rst_lo",   64'(bus.lo), 64'(12));
        check("post_rst_hi",   64'(bus.hi), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
